// File: rtl/ioc_bus_master.sv
// ioc_bus_master: turns SPI command/data bytes into one-cycle load/fetch
// strobes on the shared IOC bus, captures read-back bytes for the SPI
// transmitter, and always leaves a chip-select-low GAP cycle between
// transactions.
module ioc_bus_master #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic        i_sys_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  input  logic        i_frame_active,
  input  logic [31:0] i_rd_data,
  output logic [3:0]  o_cs,
  output logic [4:0]  o_ioc,
  output logic [7:0]  o_data,
  output logic        o_load_cmd,
  output logic        o_fetch_cmd,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_load,
  output logic        o_busy,
  output logic        o_timeout,
  output logic        o_overrun
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_DATA = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_REQ  = 3'd3;
  localparam logic [2:0] READ_CAP  = 3'd4;
  localparam logic [2:0] GAP       = 3'd5;

  // Compared one bit wider than the timer so a limit of 255 still fits.
  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);

  logic [2:0]      state, nxt;
  logic [1:0]      mod, mod_nxt;
  logic [7:0]      timer;
  logic            accept, take_data, tmo_hit, drop;
  logic [3:0][7:0] rd_bytes;

  assign rd_bytes = i_rd_data;

  // Next-state decode; outputs are registered from the next state so every
  // strobe lines up with the state it belongs to.
  always_comb begin
    nxt       = state;
    mod_nxt   = mod;
    accept    = 1'b0;
    take_data = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_valid && i_frame_active) begin
          accept  = 1'b1;
          mod_nxt = i_rx_byte[6:5];
          nxt     = i_rx_byte[7] ? WAIT_DATA : READ_REQ;
        end
      end
      WAIT_DATA: begin
        // Data byte wins over frame drop, which wins over timeout.
        if (i_rx_valid) begin
          take_data = 1'b1;
          nxt       = WRITE;
        end else if (!i_frame_active) begin
          nxt = IDLE;
        end else if ({1'b0, timer} + 9'd1 == TMO_LIMIT) begin
          tmo_hit = 1'b1;
          nxt     = IDLE;
        end
      end
      WRITE:    nxt = GAP;
      READ_REQ: nxt = READ_CAP;
      READ_CAP: nxt = GAP;
      GAP:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    drop = i_rx_valid && (state inside {WRITE, READ_REQ, READ_CAP, GAP});
  end

  // State, latched module index and WAIT_DATA timer.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      mod   <= 2'd0;
      timer <= 8'd0;
    end else begin
      state <= nxt;
      mod   <= mod_nxt;
      // Abort happens at the limit, so the timer never wraps.
      if (state == WAIT_DATA && nxt == WAIT_DATA) timer <= timer + 8'd1;
      else                                        timer <= 8'd0;
    end
  end

  // Registered bus outputs and status pulses.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cs        <= 4'd0;
      o_ioc       <= 5'd0;
      o_data      <= 8'd0;
      o_load_cmd  <= 1'b0;
      o_fetch_cmd <= 1'b0;
      o_tx_byte   <= 8'd0;
      o_tx_load   <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_cs        <= (nxt inside {WRITE, READ_REQ, READ_CAP}) ?
                     4'(4'b0001 << mod_nxt) : 4'd0;
      o_load_cmd  <= (nxt == WRITE);
      o_fetch_cmd <= (nxt == READ_REQ);
      o_busy      <= (nxt != IDLE);
      o_timeout   <= tmo_hit;
      o_overrun   <= drop;
      o_tx_load   <= (state == READ_CAP);
      if (accept)             o_ioc     <= i_rx_byte[4:0];
      if (take_data)          o_data    <= i_rx_byte;
      if (state == READ_CAP)  o_tx_byte <= rd_bytes[mod];
    end
  end

endmodule

// File: tb/tb_ioc_bus_master.sv
// tb_ioc_bus_master: directed stimulus pushes expected bus events into a
// queue; a negedge monitor pops and compares each strobe the DUT presents.
module tb_ioc_bus_master;
  localparam int TMO = 24;

  localparam int EV_LOAD  = 0;
  localparam int EV_FETCH = 1;
  localparam int EV_TXL   = 2;
  localparam int EV_TMO   = 3;
  localparam int EV_OVR   = 4;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] cs;
    logic [4:0] ioc;
    logic [7:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        frame_active = 1'b0;
  logic [31:0] rd_data = 32'h3C960FA5;
  logic [3:0]  cs;
  logic [4:0]  ioc;
  logic [7:0]  data, tx_byte;
  logic        load_cmd, fetch_cmd, tx_load, busy, timeout, overrun;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q[$];

  ioc_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_sys_clk(clk), .i_rst(rst), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .i_frame_active(frame_active), .i_rd_data(rd_data),
    .o_cs(cs), .o_ioc(ioc), .o_data(data), .o_load_cmd(load_cmd),
    .o_fetch_cmd(fetch_cmd), .o_tx_byte(tx_byte), .o_tx_load(tx_load),
    .o_busy(busy), .o_timeout(timeout), .o_overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input string info);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, info);
  endtask

  task automatic expect_ev(input int c, input int k, input logic [3:0] ecs,
                           input logic [4:0] eioc, input logic [7:0] v);
    exp_t e;
    e.cyc = c; e.kind = k; e.cs = ecs; e.ioc = eioc; e.val = v;
    q.push_back(e);
  endtask

  task automatic match(input int k, input logic [7:0] v);
    exp_t e;
    bit   ok;
    if (q.size() == 0) begin
      check("unexpected_event", 1'b0,
            $sformatf("kind %0d at cycle %0d, required none", k, cyc));
    end else begin
      e  = q.pop_front();
      ok = (e.kind == k) && (e.cyc == cyc);
      if (k == EV_LOAD || k == EV_TXL) ok = ok && cs == e.cs && ioc == e.ioc && v == e.val;
      if (k == EV_FETCH)               ok = ok && cs == e.cs && ioc == e.ioc;
      check("event", ok,
            $sformatf("got kind %0d cyc %0d cs %b ioc %h val %h, required kind %0d cyc %0d cs %b ioc %h val %h",
                      k, cyc, cs, ioc, v, e.kind, e.cyc, e.cs, e.ioc, e.val));
    end
  endtask

  // Monitor: bus invariants every cycle, scoreboard pop on each strobe.
  always @(negedge clk) begin
    check("invariant", $onehot0(cs) && !(load_cmd && fetch_cmd),
          $sformatf("cs %b load %b fetch %b, required onehot0 and not both", cs, load_cmd, fetch_cmd));
    if (load_cmd)  match(EV_LOAD, data);
    if (fetch_cmd) match(EV_FETCH, 8'h00);
    if (tx_load)   match(EV_TXL, tx_byte);
    if (timeout)   match(EV_TMO, 8'h00);
    if (overrun)   match(EV_OVR, 8'h00);
  end

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check(name, {cs, ioc, data, load_cmd, fetch_cmd, tx_byte, tx_load, busy, timeout, overrun} == 31'd0,
          $sformatf("cs %b ioc %h data %h tx %h busy %b, required all 0", cs, ioc, data, tx_byte, busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    frame_active = 1'b1;
    @(negedge clk);

    // Write module 2 IOC 6, data 20 cycles after the command.
    n = cyc;
    send(8'hC6);
    goto(n + 20);
    expect_ev(cyc + 1, EV_LOAD, 4'b0100, 5'd6, 8'h5A);
    send(8'h5A);
    @(negedge clk);
    check("gap", cs == 4'd0 && busy, $sformatf("cs %b busy %b, required 0000 1", cs, busy));
    @(negedge clk);
    check("idle_hold", !busy && ioc == 5'd6 && data == 8'h5A,
          $sformatf("busy %b ioc %h data %h, required 0 06 5a", busy, ioc, data));

    // Reads from modules 0 and 3.
    n = cyc;
    expect_ev(n + 1, EV_FETCH, 4'b0001, 5'h03, 8'h00);
    expect_ev(n + 3, EV_TXL,   4'b0000, 5'h03, 8'hA5);
    send(8'h03);
    goto(n + 4);
    check("read_idle", !busy, $sformatf("busy %b, required 0", busy));
    n = cyc;
    expect_ev(n + 1, EV_FETCH, 4'b1000, 5'h0B, 8'h00);
    expect_ev(n + 3, EV_TXL,   4'b0000, 5'h0B, 8'h3C);
    send(8'h6B);
    goto(n + 4);

    // Write with no data byte times out TMO cycles after WAIT_DATA entry.
    n = cyc;
    expect_ev(n + 1 + TMO, EV_TMO, 4'b0, 5'h0, 8'h00);
    send(8'h84);
    goto(n + 1 + TMO);
    check("tmo_idle", !busy, $sformatf("busy %b, required 0", busy));
    n = cyc;
    expect_ev(n + 1, EV_FETCH, 4'b0010, 5'h05, 8'h00);
    expect_ev(n + 3, EV_TXL,   4'b0000, 5'h05, 8'h0F);
    send(8'h25);
    goto(n + 4);

    // Data byte on the last cycle before timeout still wins.
    n = cyc;
    send(8'hA7);
    goto(n + TMO);
    expect_ev(cyc + 1, EV_LOAD, 4'b0010, 5'h07, 8'h3C);
    send(8'h3C);
    goto(cyc + 2);

    // Byte with frame inactive in IDLE is ignored.
    frame_active = 1'b0;
    send(8'hC6);
    check("ignored", !busy, $sformatf("busy %b, required 0", busy));
    frame_active = 1'b1;

    // Frame drop while waiting for data: silent abort.
    send(8'h91);
    repeat (2) @(negedge clk);
    frame_active = 1'b0;
    @(negedge clk);
    check("drop_idle", !busy, $sformatf("busy %b, required 0", busy));
    frame_active = 1'b1;
    repeat (2) @(negedge clk);

    // Frame drop during WRITE: write completes.
    send(8'hE2);
    expect_ev(cyc + 1, EV_LOAD, 4'b1000, 5'h02, 8'h77);
    send(8'h77);
    frame_active = 1'b0;
    goto(cyc + 3);
    frame_active = 1'b1;

    // Extra byte during READ_REQ: overrun, read unaffected.
    n = cyc;
    expect_ev(n + 1, EV_FETCH, 4'b0100, 5'h02, 8'h00);
    expect_ev(n + 2, EV_OVR,   4'b0000, 5'h00, 8'h00);
    expect_ev(n + 3, EV_TXL,   4'b0000, 5'h02, 8'h96);
    send(8'h42);
    send(8'h99);
    goto(n + 5);
    check("not_decoded", !busy && ioc == 5'h02,
          $sformatf("busy %b ioc %h, required 0 02", busy, ioc));

    // Reset during READ_CAP: outputs cleared, no tx_load.
    n = cyc;
    expect_ev(n + 1, EV_FETCH, 4'b0001, 5'h03, 8'h00);
    send(8'h03);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'hA9);
    expect_ev(cyc + 1, EV_LOAD, 4'b0010, 5'h09, 8'h11);
    send(8'h11);
    goto(cyc + 4);

    check("drained", q.size() == 0, $sformatf("%0d events pending, required 0", q.size()));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ioc_bus_master.md
# ioc_bus_master

Command sequencer between the SPI byte receiver and the IOC-addressed register modules (system control, RX/TX paths, etc.). It decodes one command byte, plus one data byte for writes, into a single-cycle load or fetch strobe on the shared IOC bus with a one-hot module select. For reads it captures the selected module's response byte and hands it to the SPI transmitter. It guarantees a chip-select-low gap between transactions, so modules that clear pending commands on `cs` low behave correctly.

## Interface
- `TIMEOUT_CYCLES`, 200: WAIT_DATA cycles allowed for a write's data byte before abort; legal range 1..255.
- `i_sys_clk` in 1: system clock; all logic on rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_rx_byte` in 8: received SPI byte.
- `i_rx_valid` in 1: one-cycle strobe, `i_rx_byte` valid.
- `i_frame_active` in 1: SPI frame (host CS) active.
- `i_rd_data` in 32: module read-back bytes; module k on bits [8k+7:8k].
- `o_cs` out 4: one-hot module select.
- `o_ioc` out 5: IOC address.
- `o_data` out 8: write data.
- `o_load_cmd` out 1: write strobe.
- `o_fetch_cmd` out 1: read strobe.
- `o_tx_byte` out 8: read-back byte for the SPI transmitter.
- `o_tx_load` out 1: one-cycle strobe, `o_tx_byte` valid.
- `o_busy` out 1: high whenever state ≠ IDLE.
- `o_timeout` out 1: one-cycle pulse on a data-byte timeout abort.
- `o_overrun` out 1: one-cycle pulse when a byte is dropped.

## Operation
- Command byte: bit 7 = dir (1 write, 0 read); [6:5] = module index m; [4:0] = IOC.
- All outputs are registered. Reset value of every output and internal register is 0; state resets to IDLE.
- States:
  - **IDLE**: on `i_rx_valid` && `i_frame_active`, latch m and `o_ioc` ← byte[4:0]. Write → WAIT_DATA with timer cleared. Read → READ_REQ. A byte with `i_frame_active`=0 is ignored, with no pulse.
  - **WAIT_DATA**: on `i_rx_valid`, `o_data` ← byte, go to WRITE. Otherwise:
    - `i_frame_active`=0 → IDLE, silent abort.
    - Else the timer increments. When the timer reaches `TIMEOUT_CYCLES` → IDLE, with `o_timeout` pulsing in the following cycle.
    - Priority: byte > frame drop > timeout.
  - **WRITE** (1 cycle): `o_cs[m]`=1, `o_load_cmd`=1. Next state GAP.
  - **READ_REQ** (1 cycle): `o_cs[m]`=1, `o_fetch_cmd`=1. Next state READ_CAP.
  - **READ_CAP** (1 cycle): `o_cs[m]`=1, strobes 0. Register `o_tx_byte` ← `i_rd_data[8m+7:8m]` and `o_tx_load` ← 1, both visible next cycle. Next state GAP.
  - **GAP** (1 cycle): `o_cs`=0, strobes 0. Next state IDLE.
- Once WRITE or READ_REQ is entered, the transaction completes regardless of `i_frame_active` or new bytes.
- `i_rx_valid` in WRITE, READ_REQ, READ_CAP or GAP: byte dropped, `o_overrun` pulses the next cycle.
- Output behaviour:
  - `o_ioc` and `o_data` hold their last values between transactions.
  - `o_cs` is zero outside WRITE, READ_REQ and READ_CAP.
  - At most one `o_cs` bit is ever set.
  - `o_load_cmd` and `o_fetch_cmd` are never high together.
- Timer is 8 bits; it saturates by construction because the abort occurs at `TIMEOUT_CYCLES`.
- An `i_rst` assertion mid-transaction immediately forces all outputs to 0 and state to IDLE. The partial transaction is lost, with no strobe.

## Timing
- Write, data byte strobed at cycle N:
  - N+1: `o_cs[m]` and `o_load_cmd` high.
  - N+2: GAP.
  - N+3: IDLE; a new command byte is accepted at N+3.
- Read, command byte strobed at cycle N:
  - N+1: `o_cs[m]` and `o_fetch_cmd` high.
  - N+2: `o_cs[m]` high; `i_rd_data` sampled at the end of N+2.
  - N+3: `o_tx_byte` and `o_tx_load` valid (state GAP).
  - N+4: IDLE.
- Modules must present read data within one cycle of the fetch strobe.
- Timeout: WAIT_DATA entered at cycle E with no byte → state IDLE from E+`TIMEOUT_CYCLES`, `o_timeout` pulse in that same cycle.
- `o_busy` is high from the cycle after command-byte acceptance until the cycle state returns to IDLE.

## Test plan
- Write 0xC6 (module 2, IOC 6) then 0x5A, bytes 20 cycles apart → single cycle with `o_cs`=0100, `o_ioc`=6, `o_data`=0x5A, `o_load_cmd`=1, exactly one cycle after the data strobe; `o_cs`=0 the following cycle.
- Read 0x03 with `i_rd_data`[7:0]=0xA5 → `o_fetch_cmd` at N+1 with `o_cs`=0001; `o_tx_byte`=0xA5 and `o_tx_load`=1 at N+3.
- Write command 0x84 with no data byte, `TIMEOUT_CYCLES`=10 → no `o_load_cmd`; `o_timeout` pulses once, 10 cycles after WAIT_DATA entry; next command accepted normally.
- Write command, then drop `i_frame_active` before the data byte → silent return to IDLE, no strobes, no `o_timeout`. In a separate run, drop `i_frame_active` in the WRITE cycle → write still completes.
- Extra `i_rx_valid` in READ_REQ → `o_overrun` pulses once; read completes with correct data; the dropped byte is not decoded.
- Assert `i_rst` during READ_CAP → all outputs 0 immediately, no `o_tx_load`; after release, a write to module 1 works.
